// File: rtl/fp_int_acc_pkg.sv
// +----------------------------------------------------------------------------+
// | Package : fp_int_pkg                                                       |
// | Shared constants, FSM encoding and fp32 packing helper for fp_int_acc.     |
// | FP_INT_ACC_ROUND_RNE_EN adds the NORM2 rounding state.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package fp_int_pkg;

  localparam int          FP16_BIAS  = 15;
  localparam int          FP32_BIAS  = 127;
  localparam int          MANT_FRAC  = 10;
  localparam int          LSB_EXP    = -24;
  // Leading-one index p maps to an fp32 biased exponent of p + LSB_EXP + FP32_BIAS.
  localparam int          EXP_OFFSET = 103;
  localparam logic [31:0] FP32_QNAN  = 32'h7FC0_0000;

`ifdef FP_INT_ACC_ROUND_RNE_EN
  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_NORM  = 2'd1,
    ST_OUT   = 2'd2,
    ST_NORM2 = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_NORM = 2'd1,
    ST_OUT  = 2'd2
  } state_t;
`endif

  function automatic logic [31:0] fp32_pack(input logic       sgn,
                                            input logic [7:0] exp,
                                            input logic [22:0] man);
    return {sgn, exp, man};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_int_acc_lead_one_det.sv
// +----------------------------------------------------------------------------+
// | Module  : lead_one_det                                                     |
// | Combinational leading-one detector: index of the highest set bit + zero.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module lead_one_det #(
  parameter int WIDTH = 48,
  parameter int POS_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] din,
  output logic [POS_W-1:0] pos,
  output logic             zero
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) pos = POS_W'(i);
    end
  end

  assign zero = (din == '0);

endmodule

`default_nettype wire

// File: rtl/fp_int_acc.sv
// +----------------------------------------------------------------------------+
// | Module  : fp_int_acc                                                       |
// | Exact fixed-point accumulation of fp16 x int4 products, fp32 normalisation.|
// | Define FP_INT_ACC_ROUND_RNE_EN for round-to-nearest-even (+1 cycle).       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fp_int_acc
  import fp_int_pkg::*;
#(
  parameter int NUM_TERMS  = 16,
  parameter int ACC_WIDTH  = 48,
  parameter int MANT_WIDTH = 14,
  parameter int EXP_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_acc,
  input  logic                  sign_in,
  input  logic [EXP_WIDTH-1:0]  exp_in,
  input  logic [MANT_WIDTH-1:0] mant_in,
  input  logic                  clear,
  output logic                  acc_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [31:0]           result,
  output logic                  drop_err,
  output logic [4:0]            term_cnt
);

  localparam int         POS_W       = $clog2(ACC_WIDTH);
  localparam logic [4:0] C_LAST_TERM = 5'(NUM_TERMS);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [4:0]           r_term_cnt;
  logic                 r_special;
  logic                 r_drop_err;
  logic [31:0]          r_result;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_handshake;
  logic [EXP_WIDTH-1:0] w_shamt;
  logic                 w_exp_special;
  logic [ACC_WIDTH-1:0] w_term_mag;
  logic [ACC_WIDTH-1:0] w_term;

  assign acc_ready   = rst && (r_state == ST_ACC);
  assign res_valid   = (r_state == ST_OUT);
  assign result      = r_result;
  assign drop_err    = r_drop_err;
  assign term_cnt    = r_term_cnt;

  assign w_accept    = start_acc && acc_ready && !clear;
  assign w_last      = w_accept && ((r_term_cnt + 5'd1) == C_LAST_TERM);
  assign w_handshake = (r_state == ST_OUT) && res_ready;

  // Subnormal fp16 exponent 0 carries the same weight as exponent 1.
  assign w_exp_special = (exp_in == '1);
  assign w_shamt       = (exp_in == '0) ? '0 : (exp_in - EXP_WIDTH'(1));
  assign w_term_mag    = ACC_WIDTH'(mant_in) << w_shamt;
  assign w_term        = sign_in ? -w_term_mag : w_term_mag;

  // Normalisation of the two's-complement sum.
  logic                 w_neg;
  logic [ACC_WIDTH-1:0] w_mag;
  logic [ACC_WIDTH-1:0] w_norm;
  logic [POS_W-1:0]     w_pos;
  logic [POS_W-1:0]     w_shift;
  logic                 w_zero;
  logic [7:0]           w_exp;

  assign w_neg   = r_acc[ACC_WIDTH-1];
  assign w_mag   = w_neg ? -r_acc : r_acc;

  lead_one_det #(
    .WIDTH (ACC_WIDTH),
    .POS_W (POS_W)
  ) u_lead_one_det (
    .din  (w_mag),
    .pos  (w_pos),
    .zero (w_zero)
  );

  assign w_shift = POS_W'(ACC_WIDTH - 1) - w_pos;
  assign w_norm  = w_mag << w_shift;
  assign w_exp   = 8'(w_pos) + 8'(EXP_OFFSET);

  logic        w_res_neg;
  logic        w_res_zero;
  logic [7:0]  w_res_exp;
  logic [22:0] w_res_mant;
  logic        w_res_load;
  logic [31:0] w_res_nxt;
  logic        w_unused;

`ifdef FP_INT_ACC_ROUND_RNE_EN
  logic [ACC_WIDTH-2:0] r_frac;
  logic [7:0]           r_exp;
  logic                 r_neg;
  logic                 r_zero;
  logic                 w_guard;
  logic                 w_lsb;
  logic                 w_sticky;
  logic                 w_round_up;
  logic [23:0]          w_rnd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frac <= '0;
      r_exp  <= '0;
      r_neg  <= 1'b0;
      r_zero <= 1'b0;
    end else if (r_state == ST_NORM) begin
      r_frac <= w_norm[ACC_WIDTH-2:0];
      r_exp  <= w_exp;
      r_neg  <= w_neg;
      r_zero <= w_zero;
    end
  end

  assign w_lsb      = r_frac[ACC_WIDTH-24];
  assign w_guard    = r_frac[ACC_WIDTH-25];
  assign w_sticky   = |r_frac[ACC_WIDTH-26:0];
  assign w_round_up = w_guard && (w_sticky || w_lsb);
  // An all-ones mantissa rounding up wraps to zero and bumps the exponent.
  assign w_rnd      = {1'b0, r_frac[ACC_WIDTH-2 -: 23]} + 24'(w_round_up);

  assign w_res_neg  = r_neg;
  assign w_res_zero = r_zero;
  assign w_res_exp  = r_exp + 8'(w_rnd[23]);
  assign w_res_mant = w_rnd[22:0];
  assign w_res_load = (r_state == ST_NORM2);
  assign w_unused   = w_norm[ACC_WIDTH-1];
`else
  assign w_res_neg  = w_neg;
  assign w_res_zero = w_zero;
  assign w_res_exp  = w_exp;
  assign w_res_mant = w_norm[ACC_WIDTH-2 -: 23];
  assign w_res_load = (r_state == ST_NORM);
  assign w_unused   = ^{w_norm[ACC_WIDTH-1], w_norm[ACC_WIDTH-25:0]};
`endif

  assign w_res_nxt = r_special  ? FP32_QNAN :
                     w_res_zero ? 32'h0000_0000 :
                                  fp32_pack(w_res_neg, w_res_exp, w_res_mant);

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_ACC;
    end else begin
      case (r_state)
        ST_ACC:   if (w_last) w_state_nxt = ST_NORM;
`ifdef FP_INT_ACC_ROUND_RNE_EN
        ST_NORM:  w_state_nxt = ST_NORM2;
        ST_NORM2: w_state_nxt = ST_OUT;
`else
        ST_NORM:  w_state_nxt = ST_OUT;
`endif
        ST_OUT:   if (res_ready) w_state_nxt = ST_ACC;
        default:  w_state_nxt = ST_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_ACC;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc      <= '0;
      r_term_cnt <= '0;
      r_special  <= 1'b0;
      r_drop_err <= 1'b0;
      r_result   <= '0;
    end else begin
      if (start_acc && !acc_ready) r_drop_err <= 1'b1;

      if (clear || w_handshake) begin
        r_acc      <= '0;
        r_term_cnt <= '0;
        r_special  <= 1'b0;
      end else if (w_accept) begin
        r_term_cnt <= r_term_cnt + 5'd1;
        // Inf/NaN operands are counted but poison the result instead of summing.
        if (w_exp_special) r_special <= 1'b1;
        else               r_acc     <= r_acc + w_term;
      end

      if (clear)           r_result <= '0;
      else if (w_res_load) r_result <= w_res_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_int_acc.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_fp_int_acc                                                    |
// | Directed scoreboard bench for fp_int_acc with NUM_TERMS = 4.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fp_int_acc;

  localparam int NT = 4;
`ifdef FP_INT_ACC_ROUND_RNE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_acc = 1'b0;
  logic        sign_in = 1'b0;
  logic [4:0]  exp_in = '0;
  logic [13:0] mant_in = '0;
  logic        clear = 1'b0;
  logic        acc_ready;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] result;
  logic        drop_err;
  logic [4:0]  term_cnt;

  fp_int_acc #(
    .NUM_TERMS  (NT),
    .ACC_WIDTH  (48),
    .MANT_WIDTH (14),
    .EXP_WIDTH  (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_acc (start_acc),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .mant_in   (mant_in),
    .clear     (clear),
    .acc_ready (acc_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .drop_err  (drop_err),
    .term_cnt  (term_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cnt = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard side: latency on the rising valid, value on every valid cycle.
  task automatic monitor();
    if (res_valid && !prev_valid) begin
      if (sb.size() == 0) check("unexpected_valid", {31'b0, res_valid}, 32'd0);
      else                check("latency", cnt, sb[0].due);
    end
    if (res_valid && sb.size() > 0) check("result", result, sb[0].res);
    if (res_valid && res_ready && sb.size() > 0) void'(sb.pop_front());
    prev_valid = res_valid;
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cnt++;
    #1;
  endtask

  task automatic term(input logic s, input logic [4:0] e, input logic [13:0] m,
                      input logic last, input logic [31:0] expres);
    if (last) sb.push_back('{res: expres, due: cnt + LAT});
    start_acc = 1'b1;
    sign_in   = s;
    exp_in    = e;
    mant_in   = m;
    cyc();
    start_acc = 1'b0;
  endtask

  task automatic four_same(input logic s, input logic [4:0] e, input logic [13:0] m,
                           input logic [31:0] expres);
    for (int i = 0; i < NT; i++) term(s, e, m, (i == NT - 1), expres);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      cyc();
      n++;
    end
    check("drain_timeout", sb.size(), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) cyc();
    check("rst_acc_ready", {31'b0, acc_ready}, 32'd0);
    check("rst_res_valid", {31'b0, res_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_drop_err", {31'b0, drop_err}, 32'd0);
    check("rst_term_cnt", {27'b0, term_cnt}, 32'd0);
    rst = 1'b1;
    cyc();
    check("acc_ready_idle", {31'b0, acc_ready}, 32'd1);

    // Four 1.0 terms -> 4.0
    res_ready = 1'b1;
    four_same(1'b0, 5'd15, 14'h0400, 32'h4080_0000);
    drain();
    check("valid_one_cycle", {31'b0, res_valid}, 32'd0);
    check("term_cnt_cleared", {27'b0, term_cnt}, 32'd0);
    check("acc_ready_after", {31'b0, acc_ready}, 32'd1);

    // +3.0 - 1.0 - 1.0 - 1.0 -> +0
    term(1'b0, 5'd15, 14'h0C00, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) term(1'b1, 5'd15, 14'h0400, (i == 2), 32'h0000_0000);
    drain();

    // Largest terms
    four_same(1'b0, 5'd30, 14'h3FFF, 32'h49FF_FC00);
    drain();

    // Negative sum -2.0
    four_same(1'b1, 5'd15, 14'h0200, 32'hC000_0000);
    drain();

    // Subnormal exponent 0: each term 2^-14, sum 2^-12
    four_same(1'b0, 5'd0, 14'h0400, 32'h3980_0000);
    drain();

    // Special exponent poisons the sum
    term(1'b0, 5'd31, 14'h0400, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) term(1'b0, 5'd15, 14'h0400, (i == 2), 32'h7FC0_0000);
    drain();
    check("drop_err_still0", {31'b0, drop_err}, 32'd0);

    // Backpressure: hold result, dropped product sets drop_err
    res_ready = 1'b0;
    four_same(1'b0, 5'd15, 14'h0400, 32'h4080_0000);
    for (int n = 0; n < 10 && !res_valid; n++) cyc();
    check("stall_valid", {31'b0, res_valid}, 32'd1);
    check("stall_term_cnt", {27'b0, term_cnt}, 32'd4);
    for (int i = 0; i < 5; i++) begin
      check("stall_acc_ready", {31'b0, acc_ready}, 32'd0);
      start_acc = (i == 2);
      exp_in    = 5'd15;
      mant_in   = 14'h0400;
      cyc();
      start_acc = 1'b0;
    end
    check("drop_err_set", {31'b0, drop_err}, 32'd1);
    res_ready = 1'b1;
    drain();
    four_same(1'b0, 5'd15, 14'h0400, 32'h4080_0000);
    drain();

    // Clear discards a partial sum
    term(1'b0, 5'd15, 14'h0C00, 1'b0, 32'h0);
    term(1'b0, 5'd15, 14'h0C00, 1'b0, 32'h0);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("clear_term_cnt", {27'b0, term_cnt}, 32'd0);
    four_same(1'b0, 5'd15, 14'h0400, 32'h4080_0000);
    drain();

    // Asynchronous reset mid-operation
    term(1'b0, 5'd15, 14'h0400, 1'b0, 32'h0);
    term(1'b0, 5'd15, 14'h0400, 1'b0, 32'h0);
    check("mid_term_cnt", {27'b0, term_cnt}, 32'd2);
    rst = 1'b0;
    #1;
    check("mid_rst_term_cnt", {27'b0, term_cnt}, 32'd0);
    check("mid_rst_drop_err", {31'b0, drop_err}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_acc_ready", {31'b0, acc_ready}, 32'd0);
    check("mid_rst_res_valid", {31'b0, res_valid}, 32'd0);
    cyc();
    rst = 1'b1;
    four_same(1'b0, 5'd15, 14'h0400, 32'h4080_0000);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
